mux8to1: RTL and testbench
==========================

MUX8TO1 -- requirements
Module: mux8to1

Interface
REQ-001 Parameter: DATA_W, default 1, width of each data input lane and of the output.
REQ-002 Port: clk  input  1  rising-edge clock for all registered state.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low, sampled on rising clk.
REQ-004 Port: I  input  8*DATA_W  eight packed data lanes; lane k occupies bits [k*DATA_W +: DATA_W].
REQ-005 Port: S  input  3  lane select, unsigned 0..7.
REQ-006 Port: Y  output  DATA_W  selected lane.
REQ-007 Port: y_q  output  DATA_W  registered copy of the selected lane.
REQ-008 Port: s_q  output  3  registered copy of S.

Function
REQ-009 Y SHALL equal lane S of I, i.e. Y = I[S*DATA_W +: DATA_W], for all eight S values.
- No out-of-range case exists; no default or X output.
REQ-010 Without the configuration macro, Y SHALL be purely combinational.
- Zero latency.
- Y SHALL follow any change on I or S within the same time step.
- Y SHALL NOT depend on clk or rst_n.
REQ-011 On each rising clk with rst_n=1:
- y_q SHALL load the REQ-009 lane value.
- s_q SHALL load S.
- Latency is exactly 1 cycle.
REQ-012 A change on I alone SHALL update Y in the same cycle (combinational build) and y_q on the next edge.
REQ-013 Simultaneous change of S and I SHALL select the new lane of the new I; no glitch-free guarantee is required on combinational Y.

Reset
REQ-014 When rst_n=0 at a rising clk edge, y_q SHALL become all-zeros and s_q SHALL become 3'b000.
REQ-015 Reset SHALL have no effect between clock edges.
REQ-016 Reset asserted mid-operation SHALL override the load of REQ-011 on that same edge.
REQ-017 The first edge after rst_n returns to 1 SHALL load normally.
REQ-018 Combinational Y SHALL be unaffected by reset in the default build.

Configuration
REQ-019 Macro MUX8TO1_REG_OUT_EN.
- When defined, Y SHALL be driven from y_q: 1-cycle latency, zero after reset.
- When undefined, Y SHALL be combinational per REQ-010.
- y_q and s_q SHALL behave identically in both builds.

Structure
REQ-020 A shared package SHALL hold the following; no other typedefs are required:
- the lane count constant (8),
- the select width constant (3),
- the DATA_W default.
REQ-021 The select logic SHALL be built from a sub-module mux2to1 (DATA_W-wide, one select bit), instantiated as a 3-level tree of 7 instances.
- Level 1 (4 instances) uses S[0].
- Level 2 (2 instances) uses S[1].
- Level 3 (1 instance) uses S[2].

Verification
REQ-022 DATA_W=1, I=8'b1010_1101, S stepped 0..7 at 5-time-unit intervals -> Y = 1,0,1,1,0,1,0,1 (default build, no clock needed).
REQ-023 Same I, clocked, S=3'b010 then 3'b100 -> y_q = 1 one cycle after S=3'b010 and 0 one cycle after S=3'b100; s_q tracks S with 1-cycle delay.
REQ-024 rst_n=0 for 2 edges with I=8'hFF, S=3'b111 -> y_q=0 and s_q=000 after the first edge; y_q=1 one edge after rst_n=1.
REQ-025 S=3'b011 held, I toggles 8'h08 -> 8'h00 -> Y goes 1 -> 0 immediately (default build); with MUX8TO1_REG_OUT_EN defined, Y changes one edge later.
REQ-026 DATA_W=4, I=32'h7654_3210, S swept 0..7 -> Y = 0,1,2,3,4,5,6,7.

Source files
------------

// File: rtl/mux8to1_pkg.sv
// Shared constants for the 8:1 mux slice.
package mux8to1_pkg;
  localparam int unsigned LANES      = 8;
  localparam int unsigned SEL_W      = 3;
  localparam int unsigned DATA_W_DEF = 1;
endpackage : mux8to1_pkg

// File: rtl/mux8to1_mux2to1.sv
// DATA_W-wide 2:1 mux; the leaf cell of the 8:1 select tree.
module mux2to1
  import mux8to1_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sel,
  output logic [DATA_W-1:0] o_y_c
);

  assign o_y_c = i_sel ? i_b : i_a;

endmodule : mux2to1

// File: rtl/mux8to1.sv
// 8:1 lane mux with registered lane/select copies.
// Define MUX8TO1_REG_OUT_EN to drive Y from the registered lane instead of the tree.
module mux8to1
  import mux8to1_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES*DATA_W-1:0] I,
  input  logic [SEL_W-1:0]        S,
  output logic [DATA_W-1:0]       Y,
  output logic [DATA_W-1:0]       y_q,
  output logic [SEL_W-1:0]        s_q
);

  logic [DATA_W-1:0] w_l1 [4];
  logic [DATA_W-1:0] w_l2 [2];
  logic [DATA_W-1:0] w_y;
  logic [DATA_W-1:0] r_y_q;
  logic [SEL_W-1:0]  r_s_q;

  // Level 1: adjacent lane pairs, split by S[0]
  for (genvar k = 0; k < 4; k++) begin : g_l1
    mux2to1 #(.DATA_W(DATA_W)) u_mux (
      .i_a   (I[(2*k)*DATA_W +: DATA_W]),
      .i_b   (I[(2*k+1)*DATA_W +: DATA_W]),
      .i_sel (S[0]),
      .o_y_c (w_l1[k])
    );
  end

  for (genvar k = 0; k < 2; k++) begin : g_l2
    mux2to1 #(.DATA_W(DATA_W)) u_mux (
      .i_a   (w_l1[2*k]),
      .i_b   (w_l1[2*k+1]),
      .i_sel (S[1]),
      .o_y_c (w_l2[k])
    );
  end

  mux2to1 #(.DATA_W(DATA_W)) u_l3 (
    .i_a   (w_l2[0]),
    .i_b   (w_l2[1]),
    .i_sel (S[2]),
    .o_y_c (w_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_y_q <= '0;
      r_s_q <= '0;
    end else begin
      r_y_q <= w_y;
      r_s_q <= S;
    end
  end

  assign y_q = r_y_q;
  assign s_q = r_s_q;

`ifdef MUX8TO1_REG_OUT_EN
  assign Y = r_y_q;
`else
  assign Y = w_y;
`endif

endmodule : mux8to1

// File: tb/tb_mux8to1.sv
// Scoreboard bench for mux8to1: stimulus queues expected values, a negedge monitor checks them.
module tb_mux8to1;

  logic        clk;
  logic        rst_n;
  logic [7:0]  i1;
  logic [31:0] i4;
  logic [2:0]  s;
  logic        y1, yq1;
  logic [2:0]  sq1;
  logic [3:0]  y4, yq4;
  logic [2:0]  sq4;

  mux8to1 #(.DATA_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .I(i1), .S(s), .Y(y1), .y_q(yq1), .s_q(sq1)
  );

  mux8to1 #(.DATA_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .I(i4), .S(s), .Y(y4), .y_q(yq4), .s_q(sq4)
  );

  typedef struct {
    logic        rst_n;
    logic        glitch;
    logic [7:0]  i1;
    logic [31:0] i4;
    logic [2:0]  s;
    logic        exp_y1;
    logic [3:0]  exp_y4;
  } vec_t;

  typedef struct {
    int         cyc;
    int         sig;
    int         vec;
    logic [3:0] exp;
  } chk_t;

  vec_t vecs[$];
  chk_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sig_name(input int sig);
    case (sig)
      0: return "Y_w1";
      1: return "y_q_w1";
      2: return "s_q_w1";
      3: return "Y_w4";
      4: return "y_q_w4";
      default: return "s_q_w4";
    endcase
  endfunction

  function automatic logic [3:0] sig_val(input int sig);
    case (sig)
      0: return {3'b000, y1};
      1: return {3'b000, yq1};
      2: return {1'b0, sq1};
      3: return y4;
      4: return yq4;
      default: return {1'b0, sq4};
    endcase
  endfunction

  task automatic push(input int c, input int sig, input int v, input logic [3:0] e);
    chk_t t;
    t.cyc = c; t.sig = sig; t.vec = v; t.exp = e;
    sb.push_back(t);
  endtask

  task automatic add(input logic r, input logic g, input logic [7:0] a, input logic [31:0] b,
                     input logic [2:0] sel, input logic e1, input logic [3:0] e4);
    vec_t v;
    v.rst_n = r; v.glitch = g; v.i1 = a; v.i4 = b; v.s = sel; v.exp_y1 = e1; v.exp_y4 = e4;
    vecs.push_back(v);
  endtask

  // Monitor: pops every entry due this cycle and compares at the falling edge
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        chk_t t;
        logic [3:0] act;
        t = sb.pop_front();
        act = sig_val(t.sig);
        n_checks++;
        if (t.cyc == cyc && act === t.exp) n_pass++;
        else $display("FAIL %s vec%0d cyc%0d: got %h expected %h", sig_name(t.sig), t.vec, cyc, act, t.exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0; i1 = '0; i4 = '0; s = '0;

    // reset for two edges, comb Y still live
    add(0, 0, 8'hFF, 32'h0000_0000, 3'd7, 1'b1, 4'h0);
    add(0, 0, 8'hFF, 32'h0000_0000, 3'd7, 1'b1, 4'h0);
    add(1, 0, 8'hFF, 32'h0000_0000, 3'd7, 1'b1, 4'h0);
    // I=1010_1101 sweep, wide lanes k -> k
    add(1, 0, 8'hAD, 32'h7654_3210, 3'd0, 1'b1, 4'h0);
    add(1, 0, 8'hAD, 32'h7654_3210, 3'd1, 1'b0, 4'h1);
    add(1, 0, 8'hAD, 32'h7654_3210, 3'd2, 1'b1, 4'h2);
    add(1, 0, 8'hAD, 32'h7654_3210, 3'd3, 1'b1, 4'h3);
    add(1, 0, 8'hAD, 32'h7654_3210, 3'd4, 1'b0, 4'h4);
    add(1, 0, 8'hAD, 32'h7654_3210, 3'd5, 1'b1, 4'h5);
    add(1, 0, 8'hAD, 32'h7654_3210, 3'd6, 1'b0, 4'h6);
    add(1, 0, 8'hAD, 32'h7654_3210, 3'd7, 1'b1, 4'h7);
    add(1, 0, 8'hAD, 32'h7654_3210, 3'd2, 1'b1, 4'h2);
    add(1, 0, 8'hAD, 32'h7654_3210, 3'd4, 1'b0, 4'h4);
    // I-only change with S held
    add(1, 0, 8'h08, 32'h7654_3210, 3'd3, 1'b1, 4'h3);
    add(1, 0, 8'h00, 32'h7654_3210, 3'd3, 1'b0, 4'h3);
    // reset pulse between edges must not disturb registers
    add(1, 1, 8'hAD, 32'h7654_3210, 3'd5, 1'b1, 4'h5);
    // reset mid-operation, then normal load
    add(0, 0, 8'hAD, 32'h7654_3210, 3'd6, 1'b0, 4'h6);
    add(1, 0, 8'hAD, 32'h7654_3210, 3'd7, 1'b1, 4'h7);
    // simultaneous S and I change
    add(1, 0, 8'h40, 32'hFEDC_BA98, 3'd6, 1'b1, 4'hE);
    add(1, 0, 8'h40, 32'hFEDC_BA98, 3'd1, 1'b0, 4'h9);

    foreach (vecs[n]) begin
      logic [3:0] eq1, eq4;
      logic [2:0] esq;
      @(posedge clk);
      #1;
      rst_n = vecs[n].rst_n; i1 = vecs[n].i1; i4 = vecs[n].i4; s = vecs[n].s;
      if (vecs[n].glitch) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      eq1 = vecs[n].rst_n ? {3'b000, vecs[n].exp_y1} : 4'h0;
      eq4 = vecs[n].rst_n ? vecs[n].exp_y4 : 4'h0;
      esq = vecs[n].rst_n ? vecs[n].s : 3'd0;
`ifdef MUX8TO1_REG_OUT_EN
      push(cyc + 1, 1, n, eq1);
      push(cyc + 1, 2, n, {1'b0, esq});
      push(cyc + 1, 0, n, eq1);
      push(cyc + 1, 4, n, eq4);
      push(cyc + 1, 5, n, {1'b0, esq});
      push(cyc + 1, 3, n, eq4);
`else
      push(cyc,     0, n, {3'b000, vecs[n].exp_y1});
      push(cyc,     3, n, vecs[n].exp_y4);
      push(cyc + 1, 1, n, eq1);
      push(cyc + 1, 2, n, {1'b0, esq});
      push(cyc + 1, 4, n, eq4);
      push(cyc + 1, 5, n, {1'b0, esq});
`endif
    end

    repeat (3) @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      chk_t t;
      t = sb.pop_front();
      n_checks++;
      $display("FAIL %s vec%0d: never checked, expected %h", sig_name(t.sig), t.vec, t.exp);
    end

    // Directed register checks, valid in both builds
    rst_n = 1'b1; i1 = 8'hAD; i4 = 32'h7654_3210; s = 3'd2;
    @(posedge clk);
    #1;
    n_checks++;
    if (yq1 === 1'b1) n_pass++;
    else $display("FAIL directed y_q_w1 S=2: got %b expected 1", yq1);
    n_checks++;
    if (sq1 === 3'd2) n_pass++;
    else $display("FAIL directed s_q_w1 S=2: got %0d expected 2", sq1);
    n_checks++;
    if (yq4 === 4'h2) n_pass++;
    else $display("FAIL directed y_q_w4 S=2: got %h expected 2", yq4);
    s = 3'd4;
    @(posedge clk);
    #1;
    n_checks++;
    if (yq1 === 1'b0) n_pass++;
    else $display("FAIL directed y_q_w1 S=4: got %b expected 0", yq1);
    n_checks++;
    if (yq4 === 4'h4) n_pass++;
    else $display("FAIL directed y_q_w4 S=4: got %h expected 4", yq4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (yq4 === 4'h0 && sq4 === 3'd0) n_pass++;
    else $display("FAIL directed reset w4: got y_q %h s_q %0d expected 0/0", yq4, sq4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mux8to1
